// File: rtl/alu4_or_sweep_checker_if.sv
// Operand/result and status bundle between the 4-bit OR slice sweep checker and its environment.
// The checker connects through the slave modport and the environment through the master modport.
interface alu4_or_sweep_checker_if;
    logic       start;
    logic       abort;
    logic [3:0] o;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_a;
    logic [3:0] first_fail_b;

    modport master (
        output start, abort, o,
        input  a, b, busy, done, pass, err_count,
        input  first_fail_valid, first_fail_a, first_fail_b
    );

    modport slave (
        input  start, abort, o,
        output a, b, busy, done, pass, err_count,
        output first_fail_valid, first_fail_a, first_fail_b
    );
endinterface

// File: rtl/alu4_or_sweep_checker.sv
// Walks all 256 a/b operand pairs through the 4-bit OR slice, holds each pair for SETTLE
// cycles, then compares o against a|b and keeps an error count plus the first failing pair.
module alu4_or_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    alu4_or_sweep_checker_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] TIMER_LOAD = 4'(SETTLE - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_inc;
    logic [3:0] timer;
    logic [3:0] a, b;
    logic [8:0] err_count;
    logic       ff_valid;
    logic [3:0] ff_a, ff_b;
    logic       launch, advance, mismatch;

    // Toggle order a3 (fastest), b2, a2, b1, a1, b0, a0, b3 (slowest); returns {a, b}.
    function automatic logic [7:0] vec(input logic [7:0] c);
        return {c[0], c[2], c[4], c[6], c[7], c[1], c[3], c[5]};
    endfunction

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        advance    = 1'b0;
        mismatch   = 1'b0;
        cnt_inc    = cnt + 8'd1;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (bus.start) begin
                    launch     = 1'b1;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort)          state_next = S_IDLE;
                else if (timer == '0)   state_next = S_CHECK;
            end
            S_CHECK: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else begin
                    mismatch = (bus.o != (a | b));
                    if (cnt == 8'hFF) begin
                        state_next = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_SETTLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timer     <= '0;
            a         <= '0;
            b         <= '0;
            err_count <= '0;
            ff_valid  <= 1'b0;
            ff_a      <= '0;
            ff_b      <= '0;
        end else begin
            if (launch) begin
                cnt       <= '0;
                {a, b}    <= vec('0);
                timer     <= TIMER_LOAD;
                err_count <= '0;
                ff_valid  <= 1'b0;
                ff_a      <= '0;
                ff_b      <= '0;
            end
            if (state == S_SETTLE && timer != '0) timer <= timer - 4'd1;
            if (mismatch) begin
                err_count <= err_count + 9'd1;
                if (!ff_valid) begin
                    ff_valid <= 1'b1;
                    ff_a     <= a;
                    ff_b     <= b;
                end
            end
            if (advance) begin
                cnt    <= cnt_inc;
                {a, b} <= vec(cnt_inc);
                timer  <= TIMER_LOAD;
            end
            // Operands park at zero whenever the sweep ends, by completion or abort.
            if (state_next == S_IDLE || state_next == S_DONE) begin
                a <= '0;
                b <= '0;
            end
        end
    end

    assign bus.a                = a;
    assign bus.b                = b;
    assign bus.busy             = (state == S_SETTLE) || (state == S_CHECK);
    assign bus.done             = (state == S_DONE);
    assign bus.pass             = (state == S_DONE) && (err_count == '0);
    assign bus.err_count        = err_count;
    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_a     = ff_a;
    assign bus.first_fail_b     = ff_b;

endmodule

// File: tb/tb_alu4_or_sweep_checker.sv
// Bench for the OR-slice sweep checker: a behavioural OR unit with injectable stuck-at-0 bits
// drives o, and a vector-level reference model predicts order, timing and error results.
module tb_alu4_or_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] stuck_mask = 4'b0000;
    int checks = 0;
    int errors = 0;

    alu4_or_sweep_checker_if bus ();

    alu4_or_sweep_checker #(.SETTLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // OR unit under test: one-cycle registered result with selected bits stuck at 0.
    always @(posedge clk) bus.o <= (bus.a | bus.b) & ~stuck_mask;

    // Reference vector n: bit k of n toggles the k-th signal in the list a3,b2,a2,b1,a1,b0,a0,b3.
    function automatic logic [7:0] ref_vec(input int n);
        bit      is_b [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int      pos  [8] = '{3, 2, 2, 1, 1, 0, 0, 3};
        logic [3:0] ra = '0;
        logic [3:0] rb = '0;
        for (int k = 0; k < 8; k++)
            if (((n >> k) & 1) == 1) begin
                if (is_b[k]) rb[pos[k]] = 1'b1;
                else         ra[pos[k]] = 1'b1;
            end
        return {ra, rb};
    endfunction

    // Expected error count / first failing pair after checking vectors 0..nvec-1.
    task automatic ref_results(input int nvec, input logic [3:0] mask, output int nerr,
                               output bit fv, output logic [3:0] fa, output logic [3:0] fb);
        logic [7:0] ab;
        nerr = 0; fv = 0; fa = '0; fb = '0;
        for (int n = 0; n < nvec; n++) begin
            ab = ref_vec(n);
            if (((ab[7:4] | ab[3:0]) & ~mask) != (ab[7:4] | ab[3:0])) begin
                nerr++;
                if (!fv) begin fv = 1; fa = ab[7:4]; fb = ab[3:0]; end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_valid,
             bus.first_fail_a, bus.first_fail_b} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs not all zero while rst=1 (busy=%b done=%b err=%0d)",
                     bus.busy, bus.done, bus.err_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.a, bus.b, bus.busy, bus.done, bus.pass} !== '0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d a=%b b=%b busy=%b done=%b pass=%b, expected all 0",
                         i, bus.a, bus.b, bus.busy, bus.done, bus.pass);
            end
        end
    endtask

    task automatic test_golden_sweep();
        int k;
        logic [7:0] ab;
        stuck_mask = 4'b0000;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_start: busy=%b expected 0", bus.busy);
        end
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b expected 1 one cycle after start", bus.busy);
        end
        k = 0;
        while (bus.done !== 1'b1 && k < 3000) begin
            if (k % 3 == 1) begin
                ab = ref_vec(k / 3);
                checks++;
                if ({bus.a, bus.b} !== ab) begin
                    errors++;
                    $display("FAIL sweep_order: vector %0d a=%b b=%b expected a=%b b=%b",
                             k / 3, bus.a, bus.b, ab[7:4], ab[3:0]);
                end
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 768) begin
            errors++;
            $display("FAIL done_timing: done after %0d cycles, expected 768", k);
        end
        checks++;
        if ({bus.busy, bus.pass, bus.err_count, bus.first_fail_valid, bus.a, bus.b} !==
            {1'b0, 1'b1, 9'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL golden_result: busy=%b pass=%b err=%0d ffv=%b a=%b b=%b, expected 0 1 0 0 0000 0000",
                     bus.busy, bus.pass, bus.err_count, bus.first_fail_valid, bus.a, bus.b);
        end
    endtask

    task automatic run_fault(input logic [3:0] mask, input string name);
        int cyc, nerr;
        bit fv;
        logic [3:0] fa, fb;
        stuck_mask = mask;
        pulse_start();
        wait_done(cyc);
        ref_results(256, mask, nerr, fv, fa, fb);
        checks++;
        if (bus.err_count !== 9'(nerr) || bus.pass !== (nerr == 0)) begin
            errors++;
            $display("FAIL %s_count: err=%0d pass=%b, expected err=%0d pass=%b",
                     name, bus.err_count, bus.pass, nerr, nerr == 0);
        end
        checks++;
        if ({bus.first_fail_valid, bus.first_fail_a, bus.first_fail_b} !== {fv, fa, fb}) begin
            errors++;
            $display("FAIL %s_first: ffv=%b a=%b b=%b, expected ffv=%b a=%b b=%b", name,
                     bus.first_fail_valid, bus.first_fail_a, bus.first_fail_b, fv, fa, fb);
        end
    endtask

    task automatic test_stuck_o2();
        run_fault(4'b0100, "stuck_o2");
    endtask

    task automatic test_random_faults();
        for (int i = 0; i < 3; i++) run_fault(4'($urandom_range(1, 15)), "random_fault");
    endtask

    task automatic test_start_during_busy();
        int cyc;
        stuck_mask = 4'b0000;
        pulse_start();
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3000) begin
            bus.start = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (cyc != 768 || bus.pass !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: done after %0d cycles pass=%b, expected 768 and 1",
                     cyc, bus.pass);
        end
    endtask

    task automatic test_abort();
        int nerr;
        bit fv;
        logic [3:0] fa, fb;
        stuck_mask = 4'b0100;
        pulse_start();
        repeat (31) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        ref_results(10, 4'b0100, nerr, fv, fa, fb);
        checks++;
        if ({bus.busy, bus.done, bus.a, bus.b} !== 10'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b a=%b b=%b, expected all 0",
                     bus.busy, bus.done, bus.a, bus.b);
        end
        checks++;
        if (bus.err_count !== 9'(nerr) || {bus.first_fail_valid, bus.first_fail_a, bus.first_fail_b} !== {fv, fa, fb}) begin
            errors++;
            $display("FAIL abort_partial: err=%0d ffv=%b a=%b b=%b, expected err=%0d ffv=%b a=%b b=%b",
                     bus.err_count, bus.first_fail_valid, bus.first_fail_a, bus.first_fail_b, nerr, fv, fa, fb);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_start_abort_in_done();
        int cyc;
        stuck_mask = 4'b0000;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL reach_done: done=%b after %0d cycles, expected 1", bus.done, cyc);
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_done: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.a !== 4'b0 || bus.b !== 4'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b a=%b b=%b expected 0", bus.busy, bus.a, bus.b);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        stuck_mask = 4'b0100;
        pulse_start();
        repeat (151) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_valid,
             bus.first_fail_a, bus.first_fail_b} !== '0) begin
            errors++;
            $display("FAIL async_reset: a=%b b=%b busy=%b err=%0d ffv=%b, expected all 0 without edge",
                     bus.a, bus.b, bus.busy, bus.err_count, bus.first_fail_valid);
        end
        @(negedge clk) rst = 1'b0;
        stuck_mask = 4'b0000;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != 768 || bus.pass !== 1'b1 || bus.err_count !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_sweep: cycles=%0d pass=%b err=%0d, expected 768 1 0",
                     cyc, bus.pass, bus.err_count);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_golden_sweep();
        test_stuck_o2();
        test_random_faults();
        test_start_during_busy();
        test_abort();
        test_start_abort_in_done();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
